key_conditioner: RTL



---
 rtl/key_conditioner_if.sv | 20 ++
 rtl/key_conditioner.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw active-low keys in, debounced level and event strobes out.
interface key_conditioner_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_export;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] repeat_pulse;

  modport master (
    output key_n,
    input  key_export, press_pulse, release_pulse, repeat_pulse
  );

  modport slave (
    input  key_n,
    output key_export, press_pulse, release_pulse, repeat_pulse
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, integrating debouncer and auto-repeat FSM for the DE1-SoC
// push-buttons; drives the KEY PIO level bus plus press/release/repeat strobes.
module key_conditioner #(
  parameter int unsigned NUM_KEYS            = 4,
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 5_000_000
) (
  input logic              clk_clk,
  input logic              reset_reset_n,
  key_conditioner_if.slave bus
);
  localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DB_TERM   = DEBOUNCE_CYCLES - 1;
  localparam int unsigned RP_MAX    = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned RP_W      = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
  localparam int unsigned RD_TERM   = (REPEAT_DELAY_CYCLES > 0) ? REPEAT_DELAY_CYCLES - 1 : 0;
  localparam int unsigned RR_TERM   = REPEAT_RATE_CYCLES - 1;
  localparam bit          REPEAT_EN = (REPEAT_DELAY_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rp_state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_repeat;

  // Two-flop synchronizer; idle level is released (1)
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic            r_stable;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    rp_state_t       r_state;
    rp_state_t       w_state_nxt;
    logic [RP_W-1:0] r_rp_cnt;
    logic [RP_W-1:0] w_rp_cnt_nxt;
    logic            w_repeat_nxt;
    logic            w_change;
    logic            w_accept;
    logic            w_acc_press;
    logic            w_acc_release;

    assign w_change      = r_sync2[g] ^ r_stable;
    assign w_accept      = w_change && (r_db_cnt == DB_W'(DB_TERM));
    assign w_acc_press   = w_accept && !r_sync2[g];
    assign w_acc_release = w_accept &&  r_sync2[g];

    // Integrating debouncer; any return to the stable level restarts the count
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        r_stable  <= 1'b1;
        r_db_cnt  <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_acc_press;
        r_release <= w_acc_release;
        if (!w_change) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_stable <= r_sync2[g];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        r_state  <= ST_IDLE;
        r_rp_cnt <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_rp_cnt <= w_rp_cnt_nxt;
        r_repeat <= w_repeat_nxt;
      end
    end

    // Auto-repeat: an accepted release takes priority over a coinciding tick
    always_comb begin
      w_state_nxt  = r_state;
      w_rp_cnt_nxt = r_rp_cnt;
      w_repeat_nxt = 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc_press && REPEAT_EN) begin
            w_state_nxt  = ST_DELAY;
            w_rp_cnt_nxt = '0;
          end
        end
        ST_DELAY: begin
          if (w_acc_release) begin
            w_state_nxt  = ST_IDLE;
            w_rp_cnt_nxt = '0;
          end else if (r_rp_cnt == RP_W'(RD_TERM)) begin
            w_state_nxt  = ST_REPEAT;
            w_rp_cnt_nxt = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_rp_cnt_nxt = r_rp_cnt + RP_W'(1);
          end
        end
        ST_REPEAT: begin
          if (w_acc_release) begin
            w_state_nxt  = ST_IDLE;
            w_rp_cnt_nxt = '0;
          end else if (r_rp_cnt == RP_W'(RR_TERM)) begin
            w_rp_cnt_nxt = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_rp_cnt_nxt = r_rp_cnt + RP_W'(1);
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_rp_cnt_nxt = '0;
        end
      endcase
    end

    assign w_stable[g]  = r_stable;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
    assign w_repeat[g]  = r_repeat;
  end

  assign bus.key_export    = w_stable;
  assign bus.press_pulse   = w_press;
  assign bus.release_pulse = w_release;
  assign bus.repeat_pulse  = w_repeat;
endmodule
